// File: rtl/qtable_update_sched_if.sv
// Bus bundle between the RX parser/host side and qtable_update_sched.
//   master : packet source, updater datapath and host reader (drives requests)
//   slave  : the scheduler (drives ready, start pulse, packet, grant, bank address)
// Packet packing: {type[2:0], knownCH, qvalue, energy, clusterID, hops, sourceID}.
interface qtable_update_sched_if #(
  parameter int unsigned WORD_WIDTH = 16
) ();
  localparam int unsigned PKT_W = 3 + 6 * WORD_WIDTH;

  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [PKT_W-1:0]      pkt_data;
  logic                  upd_en;
  logic [PKT_W-1:0]      upd_pkt;
  logic                  upd_done;
  logic                  upd_wr_en;
  logic [WORD_WIDTH-1:0] upd_rd_addr;
  logic                  host_rd_req;
  logic [WORD_WIDTH-1:0] host_rd_addr;
  logic                  host_rd_gnt;
  logic [WORD_WIDTH-1:0] mem_rd_addr;

  modport master (
    output pkt_valid, pkt_data, upd_done, upd_wr_en, upd_rd_addr,
           host_rd_req, host_rd_addr,
    input  pkt_ready, upd_en, upd_pkt, host_rd_gnt, mem_rd_addr
  );

  modport slave (
    input  pkt_valid, pkt_data, upd_done, upd_wr_en, upd_rd_addr,
           host_rd_req, host_rd_addr,
    output pkt_ready, upd_en, upd_pkt, host_rd_gnt, mem_rd_addr
  );
endinterface

// File: rtl/qtable_update_sched.sv
// Sequencer/arbiter in front of the Q-table update datapath.
// Buffers accepted RX packets in a small FIFO (non-routing types are dropped
// and counted), hands each one to the updater with a 1-cycle start pulse,
// waits for done under a timeout, and muxes the bank read address between
// the updater and a host reader.
// Ports:
//   clk, nrst     clock (rising edge), asynchronous active-low reset
//   bus (slave)   packet ingress, updater handshake, host/bank address mux
//   err_clr       clears the sticky timeout flag
//   busy          FSM not idle
//   err_timeout   sticky: updater did not finish within TIMEOUT_CYC
//   drop_cnt      saturating count of filtered-out packets
// Optional feature macro QSCHED_STATS_EN adds upd_cnt (commits) and
// wr_cnt (updater writes seen while waiting), both saturating.
module qtable_update_sched #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [7:0]  UPD_TYPE_MASK = 8'h22,
  parameter int unsigned TIMEOUT_CYC   = 64
) (
  input  logic                     clk,
  input  logic                     nrst,
  qtable_update_sched_if.slave     bus,
  input  logic                     err_clr,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [15:0]              drop_cnt
`ifdef QSCHED_STATS_EN
  ,
  output logic [15:0]              upd_cnt,
  output logic [15:0]              wr_cnt
`endif
);

  localparam int unsigned PKT_W = 3 + 6 * WORD_WIDTH;
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [PKT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PKT_W-1:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  upd_en_q, upd_en_d;
  logic [PKT_W-1:0]      upd_pkt_q, upd_pkt_d;
  logic                  gnt_q, gnt_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [15:0]           drop_q, drop_d;

  logic [2:0]            pkt_type;
  logic                  hs, push, drop, pop, err_set;

  // Ingress filter, FIFO bookkeeping, FSM and address arbitration.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    upd_pkt_d = upd_pkt_q;
    pop       = 1'b0;
    err_set   = 1'b0;

    pkt_type = bus.pkt_data[PKT_W-1 -: 3];
    hs       = bus.pkt_valid & ready_q;
    push     = hs & UPD_TYPE_MASK[pkt_type];
    drop     = hs & ~UPD_TYPE_MASK[pkt_type];

    case (state_q)
      S_IDLE:   if (count_q != '0) state_d = S_LOAD;
      S_LOAD: begin
        pop       = 1'b1;
        upd_pkt_d = mem_q[rd_ptr_q];
        state_d   = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done wins over a timeout landing in the same cycle
        if (bus.upd_done) begin
          state_d = S_COMMIT;
        end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = bus.pkt_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    ready_d = (count_d != CW'(FIFO_DEPTH));

    upd_en_d = (state_d == S_START);
    busy_d   = (state_d != S_IDLE);

    // Host only gets the bank when there is nothing pending for the updater
    gnt_d  = bus.host_rd_req & (state_q == S_IDLE) & (count_q == '0);
    addr_d = gnt_d ? bus.host_rd_addr : bus.upd_rd_addr;

    // A new timeout takes priority over a clear in the same cycle
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;

    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      upd_en_q  <= 1'b0;
      upd_pkt_q <= '0;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      upd_en_q  <= upd_en_d;
      upd_pkt_q <= upd_pkt_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.pkt_ready   = ready_q;
  assign bus.upd_en      = upd_en_q;
  assign bus.upd_pkt     = upd_pkt_q;
  assign bus.host_rd_gnt = gnt_q;
  assign bus.mem_rd_addr = addr_q;
  assign busy            = busy_q;
  assign err_timeout     = err_q;
  assign drop_cnt        = drop_q;

`ifdef QSCHED_STATS_EN
  logic [15:0] upd_cnt_q, upd_cnt_d, wr_cnt_q, wr_cnt_d;

  // Saturating activity counters
  always_comb begin
    upd_cnt_d = upd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    if (state_q == S_COMMIT && upd_cnt_q != 16'hFFFF) upd_cnt_d = upd_cnt_q + 16'd1;
    if (state_q == S_WAIT && bus.upd_wr_en && wr_cnt_q != 16'hFFFF)
      wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      upd_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      upd_cnt_q <= upd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign upd_cnt = upd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
`else
  // Write strobe is only monitored by the statistics counters
  logic unused_wr_en_c;
  assign unused_wr_en_c = bus.upd_wr_en;
`endif

endmodule

// File: tb/tb_qtable_update_sched.sv
// Directed bench for qtable_update_sched: single packet, drop filter,
// timeout/clear, host arbitration, back-to-back fill and mid-run reset.
module tb_qtable_update_sched;
  logic        clk;
  logic        nrst;
  logic        err_clr;
  logic        busy;
  logic        err_timeout;
  logic [15:0] drop_cnt;
`ifdef QSCHED_STATS_EN
  logic [15:0] upd_cnt;
  logic [15:0] wr_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int en_cnt      = 0;

  qtable_update_sched_if #(.WORD_WIDTH(16)) bus ();

  qtable_update_sched dut (
    .clk         (clk),
    .nrst        (nrst),
    .bus         (bus),
    .err_clr     (err_clr),
    .busy        (busy),
    .err_timeout (err_timeout),
    .drop_cnt    (drop_cnt)
`ifdef QSCHED_STATS_EN
    ,
    .upd_cnt     (upd_cnt),
    .wr_cnt      (wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses, one per high cycle
  always @(negedge clk) if (bus.upd_en === 1'b1) en_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [98:0] mkpkt(input logic [2:0] t, input logic [15:0] kch,
                                        input logic [15:0] q, input logic [15:0] e,
                                        input logic [15:0] cid, input logic [15:0] hops,
                                        input logic [15:0] src);
    return {t, kch, q, e, cid, hops, src};
  endfunction

  task automatic wait_en(input string tag);
    int n = 0;
    while (bus.upd_en !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check(tag, 128'(bus.upd_en), 128'd1);
  endtask

  logic [98:0] p1_exp;
  logic [98:0] pk [5];
  int e0;

  initial begin
    nrst             = 1'b0;
    err_clr          = 1'b0;
    bus.pkt_valid    = 1'b0;
    bus.pkt_data     = '0;
    bus.upd_done     = 1'b0;
    bus.upd_wr_en    = 1'b0;
    bus.upd_rd_addr  = '0;
    bus.host_rd_req  = 1'b0;
    bus.host_rd_addr = '0;
    repeat (3) tick();

    // Reset state
    check("rst_ready", 128'(bus.pkt_ready), 128'd1);
    check("rst_en",    128'(bus.upd_en), 128'd0);
    check("rst_pkt",   128'(bus.upd_pkt), 128'd0);
    check("rst_gnt",   128'(bus.host_rd_gnt), 128'd0);
    check("rst_addr",  128'(bus.mem_rd_addr), 128'd0);
    check("rst_busy",  128'(busy), 128'd0);
    check("rst_err",   128'(err_timeout), 128'd0);
    check("rst_drop",  128'(drop_cnt), 128'd0);
    nrst = 1'b1;
    tick();
    check("post_rst_ready", 128'(bus.pkt_ready), 128'd1);

    // Single type-5 packet, done 10 cycles after the start pulse
    p1_exp = 99'h5_0000_3000_8000_0000_0000_0001;
    e0 = en_cnt;
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = mkpkt(3'b101, 16'h0, 16'h3000, 16'h8000, 16'h0, 16'h0, 16'h1);
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    check("p1_busy_load", 128'(busy), 128'd1);
    tick();
    check("p1_en",  128'(bus.upd_en), 128'd1);
    check("p1_pkt", 128'(bus.upd_pkt), 128'(p1_exp));
    tick();
    check("p1_en_low", 128'(bus.upd_en), 128'd0);
    repeat (8) tick();
    bus.upd_done = 1'b1;
    tick();
    bus.upd_done = 1'b0;
    tick();
    check("p1_busy_done", 128'(busy), 128'd0);
    check("p1_en_pulses", 128'(en_cnt - e0), 128'd1);
    check("p1_pkt_hold",  128'(bus.upd_pkt), 128'(p1_exp));

    // Type 0 carries no routing info: dropped and counted
    e0 = en_cnt;
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = mkpkt(3'b000, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6);
    tick();
    bus.pkt_valid = 1'b0;
    check("drop_cnt", 128'(drop_cnt), 128'd1);
    repeat (6) tick();
    check("drop_no_en",  128'(en_cnt - e0), 128'd0);
    check("drop_no_busy", 128'(busy), 128'd0);

    // Updater never answers: timeout 64 cycles after entering WAIT
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = mkpkt(3'b001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h2);
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    tick();
    check("to_en", 128'(bus.upd_en), 128'd1);
    repeat (64) tick();
    check("to_err_before", 128'(err_timeout), 128'd0);
    check("to_busy_before", 128'(busy), 128'd1);
    tick();
    check("to_err_set", 128'(err_timeout), 128'd1);
    check("to_idle", 128'(busy), 128'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_clr", 128'(err_timeout), 128'd0);

    // Host read while idle and empty, then a packet takes the bank back
    bus.host_rd_req  = 1'b1;
    bus.host_rd_addr = 16'hABCD;
    bus.upd_rd_addr  = 16'h1111;
    tick();
    check("host_gnt",  128'(bus.host_rd_gnt), 128'd1);
    check("host_addr", 128'(bus.mem_rd_addr), 128'hABCD);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = mkpkt(3'b101, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3);
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    check("host_lost_gnt", 128'(bus.host_rd_gnt), 128'd0);
    check("upd_addr",      128'(bus.mem_rd_addr), 128'h1111);
    bus.host_rd_req = 1'b0;
    wait_en("host_pkt_en");
    tick();
    bus.upd_done = 1'b1;
    tick();
    bus.upd_done = 1'b0;
    tick();
    check("host_pkt_idle", 128'(busy), 128'd0);

    // Back-to-back: first packet goes to the updater, next four fill the FIFO
    e0 = en_cnt;
    for (int i = 0; i < 5; i++)
      pk[i] = mkpkt((i % 2 == 0) ? 3'b001 : 3'b101, 16'(i), 16'h10, 16'h20, 16'h30, 16'h40,
                    16'(16'h100 + i));
    for (int i = 0; i < 5; i++) begin
      bus.pkt_valid = 1'b1;
      bus.pkt_data  = pk[i];
      tick();
    end
    bus.pkt_valid = 1'b0;
    check("b2b_full", 128'(bus.pkt_ready), 128'd0);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) wait_en("b2b_en");
      check("b2b_pkt", 128'(bus.upd_pkt), 128'(pk[i]));
      tick();
      bus.upd_done = 1'b1;
      tick();
      bus.upd_done = 1'b0;
    end
    tick();
    check("b2b_idle",   128'(busy), 128'd0);
    check("b2b_ready",  128'(bus.pkt_ready), 128'd1);
    check("b2b_pulses", 128'(en_cnt - e0), 128'd5);

    // Reset mid-WAIT with two packets queued
    bus.upd_rd_addr = '0;
    for (int i = 0; i < 3; i++) begin
      bus.pkt_valid = 1'b1;
      bus.pkt_data  = mkpkt(3'b101, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'(16'h200 + i));
      tick();
    end
    bus.pkt_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", 128'(busy), 128'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("mid_rst_busy",  128'(busy), 128'd0);
    check("mid_rst_ready", 128'(bus.pkt_ready), 128'd1);
    check("mid_rst_en",    128'(bus.upd_en), 128'd0);
    check("mid_rst_pkt",   128'(bus.upd_pkt), 128'd0);
    check("mid_rst_addr",  128'(bus.mem_rd_addr), 128'd0);
    check("mid_rst_drop",  128'(drop_cnt), 128'd0);
    tick();
    nrst = 1'b1;
    e0 = en_cnt;
    repeat (10) tick();
    check("mid_no_en",   128'(en_cnt - e0), 128'd0);
    check("mid_idle",    128'(busy), 128'd0);
    check("mid_ready",   128'(bus.pkt_ready), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
